fetch_queue: RTL and testbench

- Receiving end of the fetch interface.
- Accepts the (pc, instruction) pair produced each cycle by the fetch stage and buffers it in a small FIFO.
- Presents entries to the decode stage through a valid/stall handshake.
- Drives the fetch stage's freeze input when full, and discards all buffered entries on a taken branch.
- Replaces the plain IF/ID register, decoupling fetch from decode hazards.

---
 rtl/fetch_queue_pkg.sv | 30 +++
 rtl/fetch_queue_storage.sv | 48 ++++
 rtl/fetch_queue.sv | 175 +++++++++++++++++
 tb/tb_fetch_queue.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the fetch queue slice that sits between the fetch
// stage and the decode stage.
//   WORD_WIDTH      : natural datapath width of pc and instruction words.
//   NOP_INSTRUCTION : bubble presented to decode whenever the queue is empty.
//   fetch_entry_t   : one buffered (pc, instruction) pair.
//   entry_pack      : helper that flattens a pair into the storage word layout.
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [WORD_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] pc;
        logic [WORD_WIDTH-1:0] instruction;
    } fetch_entry_t;

    // Storage word layout: pc in the upper half, instruction in the lower half.
    function automatic fetch_entry_t entry_pack(input logic [WORD_WIDTH-1:0] pc,
                                                input logic [WORD_WIDTH-1:0] instruction);
        fetch_entry_t e;
        e.pc          = pc;
        e.instruction = instruction;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue_storage.sv
// -----------------------------------------------------------------------------
// fetch_queue_storage
// DEPTH x (2*WIDTH) register array holding the buffered fetch pairs.
// Synchronous write port, combinational read port. Contents are only cleared
// by rst; a flush merely moves the pointers in the parent, leaving stale data.
//   clk, rst : clock, asynchronous active-high reset
//   we       : write enable
//   waddr    : write slot
//   wdata    : {pc, instruction} to store
//   raddr    : read slot (head of queue)
//   rdata    : {pc, instruction} at raddr
// -----------------------------------------------------------------------------
module fetch_queue_storage
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [2*WIDTH-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [2*WIDTH-1:0]       rdata
);

    logic [2*WIDTH-1:0] mem_r [DEPTH];

    // Entry array: cleared on reset, written one slot per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(2*WIDTH){1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

    // Combinational head read.
    always_comb begin
        rdata = mem_r[raddr];
    end

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Small FIFO replacing the IF/ID register. Captures the (pc, instruction) pair
// from fetch each cycle, presents the oldest entry to decode, freezes fetch
// when full and discards everything on a taken branch (flush).
//   clk, rst        : clock, asynchronous active-high reset
//   flush           : branch taken; drop contents and this cycle's input pair
//   in_valid        : fetch presents a pair
//   in_pc           : pc from fetch (already pc+4)
//   in_instruction  : instruction word from fetch
//   freeze_out      : to fetch; high while the queue is full
//   decode_stall    : decode cannot accept the head this cycle
//   out_valid       : head entry valid
//   out_pc          : head pc (0 when empty)
//   out_instruction : head instruction (bubble when empty)
// Optional build macro FETCH_QUEUE_STATS_EN adds:
//   hwm_out         : highest occupancy seen since reset
//   flushed_out     : entries discarded by flushes, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [WIDTH-1:0]           in_instruction,
    output logic                       freeze_out,
    input  logic                       decode_stall,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_pc,
`ifdef FETCH_QUEUE_STATS_EN
    output logic [WIDTH-1:0]           out_instruction,
    output logic [$clog2(DEPTH+1)-1:0] hwm_out,
    output logic [15:0]                flushed_out
`else
    output logic [WIDTH-1:0]           out_instruction
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0]      wptr_r;
    logic [AW-1:0]      rptr_r;
    logic [CW-1:0]      count_r;
    logic [AW-1:0]      wptr_next_s;
    logic [AW-1:0]      rptr_next_s;
    logic [CW-1:0]      count_next_s;
    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic [2*WIDTH-1:0] wdata_s;
    logic [2*WIDTH-1:0] rdata_s;

    // Occupancy flags and handshake qualifiers; full/empty come only from count_r.
    always_comb begin
        full_s  = (count_r == DEPTH_C);
        empty_s = (count_r == {CW{1'b0}});
        push_s  = in_valid & ~full_s & ~flush;
        pop_s   = ~empty_s & ~decode_stall & ~flush;
        wdata_s = {in_pc, in_instruction};
    end

    // Next pointer/count; flush overrides any push or pop in the same cycle.
    always_comb begin
        wptr_next_s  = wptr_r;
        rptr_next_s  = rptr_r;
        count_next_s = count_r;
        if (flush) begin
            wptr_next_s  = {AW{1'b0}};
            rptr_next_s  = {AW{1'b0}};
            count_next_s = {CW{1'b0}};
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so the increment wraps.
            if (push_s) begin
                wptr_next_s = wptr_r + AW'(1);
            end else begin
                wptr_next_s = wptr_r;
            end
            if (pop_s) begin
                rptr_next_s = rptr_r + AW'(1);
            end else begin
                rptr_next_s = rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CW'(1);
                2'b01:   count_next_s = count_r - CW'(1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            wptr_r  <= wptr_next_s;
            rptr_r  <= rptr_next_s;
            count_r <= count_next_s;
        end
    end

    fetch_queue_storage #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_storage (
        .clk   (clk),
        .rst   (rst),
        .we    (push_s),
        .waddr (wptr_r),
        .wdata (wdata_s),
        .raddr (rptr_r),
        .rdata (rdata_s)
    );

    // Decode-side outputs: decoded from registered state only, bubble when empty.
    always_comb begin
        freeze_out = full_s;
        out_valid  = ~empty_s;
        if (empty_s) begin
            out_pc          = {WIDTH{1'b0}};
            out_instruction = WIDTH'(NOP_INSTRUCTION);
        end else begin
            out_pc          = rdata_s[2*WIDTH-1:WIDTH];
            out_instruction = rdata_s[WIDTH-1:0];
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [CW-1:0] hwm_r;
    logic [15:0]   flushed_r;
    logic [16:0]   flushed_sum_s;

    // Discard accumulator with one spare bit to detect saturation.
    always_comb begin
        flushed_sum_s = {1'b0, flushed_r} + 17'(count_r);
    end

    // High-water mark tracks next occupancy so it matches count the same cycle it peaks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hwm_r     <= {CW{1'b0}};
            flushed_r <= 16'h0000;
        end else begin
            if (count_next_s > hwm_r) begin
                hwm_r <= count_next_s;
            end else begin
                hwm_r <= hwm_r;
            end
            if (flush) begin
                flushed_r <= flushed_sum_s[16] ? 16'hFFFF : flushed_sum_s[15:0];
            end else begin
                flushed_r <= flushed_r;
            end
        end
    end

    // Statistics outputs.
    always_comb begin
        hwm_out     = hwm_r;
        flushed_out = flushed_r;
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue. Stimulus pushes the expected head values into
// a scoreboard queue whenever a pair is known to be accepted; an independent
// monitor pops and compares whenever the DUT presents a head that decode takes.
// Extra directed checks cover reset, freeze, flush and async reset behaviour.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic [WIDTH-1:0]  in_pc;
    logic [WIDTH-1:0]  in_instruction;
    logic              freeze_out;
    logic              decode_stall;
    logic              out_valid;
    logic [WIDTH-1:0]  out_pc;
    logic [WIDTH-1:0]  out_instruction;
`ifdef FETCH_QUEUE_STATS_EN
    logic [2:0]        hwm_out;
    logic [15:0]       flushed_out;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_pc_q  [$];
    logic [31:0] exp_ins_q [$];

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_pc           (in_pc),
        .in_instruction  (in_instruction),
        .freeze_out      (freeze_out),
        .decode_stall    (decode_stall),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
`ifdef FETCH_QUEUE_STATS_EN
        .out_instruction (out_instruction),
        .hwm_out         (hwm_out),
        .flushed_out     (flushed_out)
`else
        .out_instruction (out_instruction)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Present a pair that is known to be accepted and record it as expected.
    task automatic send(input logic [31:0] pc, input logic [31:0] ins);
        in_valid       = 1'b1;
        in_pc          = pc;
        in_instruction = ins;
        exp_pc_q.push_back(pc);
        exp_ins_q.push_back(ins);
        tick();
    endtask

    task automatic sb_clear();
        exp_pc_q.delete();
        exp_ins_q.delete();
    endtask

    // Monitor: a head taken by decode must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && !decode_stall && !flush) begin
            if (exp_pc_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got pc 0x%08h expected no entry at %0t", out_pc, $time);
            end else begin
                chk("sb_pc", out_pc, exp_pc_q.pop_front());
                chk("sb_ins", out_instruction, exp_ins_q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] pc;
        rst            = 1'b1;
        flush          = 1'b0;
        in_valid       = 1'b0;
        in_pc          = 32'h0;
        in_instruction = 32'h0;
        decode_stall   = 1'b0;

        // Reset state.
        #2;
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_ins", out_instruction, 32'h0);
        chk("rst_freeze", {31'h0, freeze_out}, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Test 1: three pushes under stall, then drain in order.
        decode_stall = 1'b1;
        send(32'd4,  32'hE3A0_0001);
        send(32'd8,  32'hE3A0_1002);
        send(32'd12, 32'hE080_2001);
        in_valid = 1'b0;
        at_neg();
        chk("t1_valid", {31'h0, out_valid}, 32'h1);
        chk("t1_head", out_pc, 32'd4);
        chk("t1_freeze", {31'h0, freeze_out}, 32'h0);
        tick();
        at_neg();
        chk("t1_hold", out_pc, 32'd4);
        tick();
        decode_stall = 1'b0;
        tick();
        tick();
        tick();
        at_neg();
        chk("t1_empty_valid", {31'h0, out_valid}, 32'h0);
        chk("t1_empty_ins", out_instruction, 32'h0);

        // Test 2: fill, refuse a 5th pair, pop once, then accept it.
        tick();
        decode_stall = 1'b1;
        send(32'd4,  32'h1111_0004);
        send(32'd8,  32'h1111_0008);
        send(32'd12, 32'h1111_000C);
        send(32'd16, 32'h1111_0010);
        in_valid       = 1'b1;
        in_pc          = 32'd20;
        in_instruction = 32'h1111_0014;
        at_neg();
        chk("t2_full_freeze", {31'h0, freeze_out}, 32'h1);
        tick();
        decode_stall = 1'b0;
        at_neg();
        chk("t2_pop_freeze", {31'h0, freeze_out}, 32'h1);
        tick();
        decode_stall = 1'b1;
        exp_pc_q.push_back(32'd20);
        exp_ins_q.push_back(32'h1111_0014);
        at_neg();
        chk("t2_reopen", {31'h0, freeze_out}, 32'h0);
        tick();
        in_valid = 1'b0;
        at_neg();
        chk("t2_refull", {31'h0, freeze_out}, 32'h1);
        tick();
        decode_stall = 1'b0;
        repeat (4) tick();
        at_neg();
        chk("t2_drained", {31'h0, out_valid}, 32'h0);

        // Test 3: steady stream, one-cycle latency, pointer wrap.
        tick();
        for (int i = 0; i < 12; i++) begin
            pc = 32'd4 + 32'd4 * 32'(i);
            send(pc, 32'hC0DE_0000 | pc);
            chk("t3_lag", out_pc, pc);
            chk("t3_freeze", {31'h0, freeze_out}, 32'h0);
        end
        in_valid = 1'b0;
        tick();
        at_neg();
        chk("t3_done", {31'h0, out_valid}, 32'h0);

        // Test 4: flush with three queued and a pair on the input.
        tick();
        decode_stall = 1'b1;
        send(32'd1000, 32'hAAAA_03E8);
        send(32'd1004, 32'hAAAA_03EC);
        send(32'd1008, 32'hAAAA_03F0);
        in_valid       = 1'b1;
        in_pc          = 32'd100;
        in_instruction = 32'hDEAD_0064;
        flush          = 1'b1;
        sb_clear();
        tick();
        flush        = 1'b0;
        decode_stall = 1'b0;
        in_valid       = 1'b1;
        in_pc          = 32'd200;
        in_instruction = 32'h0000_BEEF;
        exp_pc_q.push_back(32'd200);
        exp_ins_q.push_back(32'h0000_BEEF);
        at_neg();
        chk("t4_flushed", {31'h0, out_valid}, 32'h0);
        tick();
        in_valid = 1'b0;
        at_neg();
        chk("t4_new_valid", {31'h0, out_valid}, 32'h1);
        chk("t4_new_pc", out_pc, 32'd200);
        tick();
        at_neg();
        chk("t4_no_stale", {31'h0, out_valid}, 32'h0);

        // Test 5: asynchronous reset mid-stream.
        tick();
        decode_stall = 1'b1;
        send(32'd500, 32'h5555_01F4);
        send(32'd504, 32'h5555_01F8);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        sb_clear();
        #1;
        chk("t5_valid", {31'h0, out_valid}, 32'h0);
        chk("t5_pc", out_pc, 32'h0);
        chk("t5_freeze", {31'h0, freeze_out}, 32'h0);
        tick();
        rst          = 1'b0;
        decode_stall = 1'b0;
        send(32'd600, 32'h6666_0258);
        in_valid = 1'b0;
        at_neg();
        chk("t5_resume", {31'h0, out_valid}, 32'h1);
        tick();
        at_neg();
        chk("t5_resume_empty", {31'h0, out_valid}, 32'h0);

`ifdef FETCH_QUEUE_STATS_EN
        // Test 6: statistics counters.
        tick();
        rst = 1'b1;
        sb_clear();
        tick();
        rst          = 1'b0;
        decode_stall = 1'b1;
        send(32'd4,  32'h7777_0004);
        send(32'd8,  32'h7777_0008);
        send(32'd12, 32'h7777_000C);
        send(32'd16, 32'h7777_0010);
        in_valid = 1'b0;
        at_neg();
        chk("t6_hwm", {29'h0, hwm_out}, 32'd4);
        tick();
        flush = 1'b1;
        sb_clear();
        tick();
        flush = 1'b0;
        send(32'd40, 32'h7777_0028);
        send(32'd44, 32'h7777_002C);
        in_valid = 1'b0;
        flush    = 1'b1;
        sb_clear();
        tick();
        flush = 1'b0;
        at_neg();
        chk("t6_flushed", {16'h0, flushed_out}, 32'd6);
        chk("t6_hwm_kept", {29'h0, hwm_out}, 32'd4);
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_hwm", {29'h0, hwm_out}, 32'd0);
        chk("t6_rst_flushed", {16'h0, flushed_out}, 32'd0);
        tick();
        rst          = 1'b0;
        decode_stall = 1'b0;
`endif

        tick();
        chk("sb_leftover", 32'(exp_pc_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
